pcie_irq_arbiter: RTL and testbench
===================================

PCIE_IRQ_ARBITER -- requirements
Module: pcie_irq_arbiter

Interface
REQ-001 Parameter RX_VECTOR, default 8'h00, message vector driven for an Rx-sourced interrupt.
REQ-002 Parameter TX_VECTOR, default 8'h01, message vector driven for a Tx-sourced interrupt.
REQ-003 clk  input  1  single clock for all logic; one clock; reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_irq_req  input  1  level request from the Rx interrupt generator.
REQ-006 tx_irq_req  input  1  level request from the Tx interrupt generator.
REQ-007 irq_enable  input  1  host-written enable; 0 blocks new grants.
REQ-008 holdoff_cycles  input  16  minimum idle gap in clk cycles after each delivered interrupt.
REQ-009 cfg_interrupt_rdy  input  1  active-high endpoint acknowledge of the pending interrupt.
REQ-010 cfg_interrupt  output  1  active-high interrupt request to the PCIe endpoint configuration port.
REQ-011 cfg_interrupt_di  output  8  vector accompanying cfg_interrupt.
REQ-012 rx_irq_ack  output  1  one-cycle pulse: Rx interrupt delivered.
REQ-013 tx_irq_ack  output  1  one-cycle pulse: Tx interrupt delivered.

Function
REQ-014 FSM states IDLE, REQ, HOLDOFF, one-hot encoded, all outputs registered.
REQ-015 IDLE: with irq_enable=1 and any request high, the block SHALL grant one source, go to REQ, and drive cfg_interrupt=1 with the granted vector in the next cycle (1-cycle latency).
REQ-016 Arbitration SHALL be round-robin: with both requests high, grant the source not granted last; with one request high, grant it; last-grant pointer resets to Tx so Rx wins the first tie.
REQ-017 REQ: cfg_interrupt and cfg_interrupt_di SHALL stay constant until cfg_interrupt_rdy is sampled high, regardless of irq_enable or request changes.
REQ-018 On the cycle after cfg_interrupt_rdy is sampled high in REQ: cfg_interrupt=0, the granted source's ack pulses for exactly one cycle, the last-grant pointer updates.
REQ-019 At handshake completion holdoff_cycles SHALL be sampled; value 0 returns to IDLE, else enter HOLDOFF for exactly holdoff_cycles cycles, then IDLE.
REQ-020 Changes to holdoff_cycles during HOLDOFF SHALL not affect the running count.
REQ-021 cfg_interrupt_rdy outside REQ SHALL be ignored.
REQ-022 irq_enable=0 in IDLE or HOLDOFF SHALL prevent a grant; pending levels are serviced once enabled.
REQ-023 Minimum spacing of consecutive cfg_interrupt rising edges SHALL be 3 + holdoff_cycles cycles when rdy returns in the first REQ cycle.
REQ-024 rx_irq_ack and tx_irq_ack SHALL never be high simultaneously.

Reset
REQ-025 Reset SHALL asynchronously force IDLE, cfg_interrupt=0, cfg_interrupt_di=8'h00, both acks 0, holdoff counter 0, last-grant=Tx.
REQ-026 Reset asserted during REQ SHALL drop cfg_interrupt immediately with no ack pulse; first post-reset grant follows REQ-015.

Structure
REQ-027 State encodings and default vector constants SHALL live in the shared package pcie_irq_pkg.
REQ-028 The holdoff count SHALL be a sub-module irq_holdoff_timer (load, 16-bit down-count, done flag).
REQ-029 Target size 120-400 RTL lines; no memories.

Verification
REQ-030 rx_irq_req=1 in IDLE, holdoff=0, rdy after 4 cycles -> cfg_interrupt high cycle 1 to 5, di=8'h00, rx_irq_ack single pulse cycle 6.
REQ-031 Both requests held high, holdoff=0, rdy immediate -> grants alternate Rx,Tx,Rx,Tx with di 00,01,00,01.
REQ-032 holdoff_cycles=10, requests continuous -> cfg_interrupt rising edges exactly 13 cycles apart; changing holdoff to 2 mid-HOLDOFF has no effect.
REQ-033 irq_enable=0 with tx_irq_req=1 for 20 cycles -> no cfg_interrupt; enable=1 -> cfg_interrupt next cycle, di=8'h01.
REQ-034 Request dropped and irq_enable cleared while in REQ -> cfg_interrupt held until rdy, ack still pulses.
REQ-035 Reset asserted mid-REQ -> cfg_interrupt 0 asynchronously, no ack; after release rx_irq_req tie resolves to Rx.

Source files
------------

// File: rtl/pcie_irq_pkg.sv
// rtl/pcie_irq_pkg.sv - shared state encodings, source ids and vector defaults for the interrupt arbiter
package pcie_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_REQ     = 3'b010,
    ST_HOLDOFF = 3'b100
  } irq_state_e;

  typedef enum logic {
    SRC_RX = 1'b0,
    SRC_TX = 1'b1
  } irq_src_e;

  localparam logic [7:0] DEF_RX_VECTOR = 8'h00;
  localparam logic [7:0] DEF_TX_VECTOR = 8'h01;

  // Round-robin choice: on a tie the source not granted last wins.
  function automatic irq_src_e rr_pick(input logic rx, input logic tx, input irq_src_e last);
    irq_src_e sel;
    if (rx && tx) begin
      if (last == SRC_TX) sel = SRC_RX;
      else                sel = SRC_TX;
    end else if (rx) begin
      sel = SRC_RX;
    end else begin
      sel = SRC_TX;
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_holdoff_timer.sv
// rtl/irq_holdoff_timer.sv - loadable 16-bit down-counter that flags when the idle gap has elapsed
module irq_holdoff_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        done_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 16'd0);

endmodule

// File: rtl/pcie_irq_arbiter.sv
// rtl/pcie_irq_arbiter.sv - round-robin Rx/Tx interrupt arbiter driving the PCIe endpoint cfg_interrupt port
module pcie_irq_arbiter
  import pcie_irq_pkg::*;
#(
  parameter logic [7:0] RX_VECTOR = DEF_RX_VECTOR,
  parameter logic [7:0] TX_VECTOR = DEF_TX_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_irq_req,
  input  logic        tx_irq_req,
  input  logic        irq_enable,
  input  logic [15:0] holdoff_cycles,
  input  logic        cfg_interrupt_rdy,
  output logic        cfg_interrupt,
  output logic [7:0]  cfg_interrupt_di,
  output logic        rx_irq_ack,
  output logic        tx_irq_ack
);

  irq_state_e state_q;
  irq_src_e   grant_q;
  irq_src_e   last_q;
  irq_src_e   pick;
  logic       cfg_int_q;
  logic [7:0] cfg_di_q;
  logic       rx_ack_q;
  logic       tx_ack_q;
  logic       hold_load;
  logic       hold_dec;
  logic       hold_done;

  assign pick      = rr_pick(rx_irq_req, tx_irq_req, last_q);
  assign hold_load = (state_q == ST_REQ) && cfg_interrupt_rdy;
  assign hold_dec  = (state_q == ST_HOLDOFF);

  // The ack cycle is spent in HOLDOFF with the freshly loaded count, so the
  // gap between grants is always the ack cycle plus holdoff_cycles.
  irq_holdoff_timer u_holdoff (
    .clk        (clk),
    .rst        (reset),
    .load_i     (hold_load),
    .load_val_i (holdoff_cycles),
    .dec_i      (hold_dec),
    .done_o     (hold_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= SRC_RX;
      last_q    <= SRC_TX;
      cfg_int_q <= 1'b0;
      cfg_di_q  <= 8'h00;
      rx_ack_q  <= 1'b0;
      tx_ack_q  <= 1'b0;
    end else begin
      rx_ack_q <= 1'b0;
      tx_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (irq_enable && (rx_irq_req || tx_irq_req)) begin
            grant_q   <= pick;
            cfg_int_q <= 1'b1;
            cfg_di_q  <= (pick == SRC_RX) ? RX_VECTOR : TX_VECTOR;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cfg_interrupt_rdy) begin
            cfg_int_q <= 1'b0;
            rx_ack_q  <= (grant_q == SRC_RX);
            tx_ack_q  <= (grant_q == SRC_TX);
            last_q    <= grant_q;
            state_q   <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hold_done) state_q <= ST_IDLE;
        end
        default: begin
          cfg_int_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_interrupt    = cfg_int_q;
  assign cfg_interrupt_di = cfg_di_q;
  assign rx_irq_ack       = rx_ack_q;
  assign tx_irq_ack       = tx_ack_q;

endmodule

// File: tb/tb_pcie_irq_arbiter.sv
// tb/tb_pcie_irq_arbiter.sv - directed table and sequence bench for pcie_irq_arbiter
module tb_pcie_irq_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_irq_req = 1'b0;
  logic        tx_irq_req = 1'b0;
  logic        irq_enable = 1'b0;
  logic [15:0] holdoff_cycles = 16'd0;
  logic        cfg_interrupt_rdy = 1'b0;
  logic        cfg_interrupt;
  logic [7:0]  cfg_interrupt_di;
  logic        rx_irq_ack;
  logic        tx_irq_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int both_acks = 0;

  typedef struct {
    logic       rx;
    logic       tx;
    logic       en;
    logic       rdy;
    logic       e_int;
    logic [7:0] e_di;
    logic       e_rack;
    logic       e_tack;
  } vec_t;

  vec_t tbl [$];

  pcie_irq_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .rx_irq_req        (rx_irq_req),
    .tx_irq_req        (tx_irq_req),
    .irq_enable        (irq_enable),
    .holdoff_cycles    (holdoff_cycles),
    .cfg_interrupt_rdy (cfg_interrupt_rdy),
    .cfg_interrupt     (cfg_interrupt),
    .cfg_interrupt_di  (cfg_interrupt_di),
    .rx_irq_ack        (rx_irq_ack),
    .tx_irq_ack        (tx_irq_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rx_irq_ack && tx_irq_ack) both_acks = both_acks + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rx, input logic tx, input logic en, input logic rdy,
                     input logic e_int, input logic [7:0] e_di, input logic e_rack, input logic e_tack);
    vec_t v;
    v.rx = rx; v.tx = tx; v.en = en; v.rdy = rdy;
    v.e_int = e_int; v.e_di = e_di; v.e_rack = e_rack; v.e_tack = e_tack;
    tbl.push_back(v);
  endtask

  task automatic wait_rise(input string name, output int t);
    logic prev;
    bit   found;
    prev  = cfg_interrupt;
    found = 1'b0;
    t     = cyc;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (cfg_interrupt && !prev) begin
        found = 1'b1;
        t     = cyc;
      end
      prev = cfg_interrupt;
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int t1, t2, t3, highs;
    logic [11:0] act, exp;

    // Outputs are {cfg_interrupt, di (only when interrupt high), rx_ack, tx_ack}.
    add(0,0,1,0, 0,8'h00,0,0);
    add(1,0,1,0, 1,8'h00,0,0);
    add(1,0,1,0, 1,8'h00,0,0);
    add(1,0,1,0, 1,8'h00,0,0);
    add(1,0,1,0, 1,8'h00,0,0);
    add(1,0,1,0, 1,8'h00,0,0);
    add(1,0,1,1, 0,8'h00,1,0);
    add(0,0,1,0, 0,8'h00,0,0);
    add(1,1,1,1, 1,8'h01,0,0);
    add(1,1,1,1, 0,8'h00,0,1);
    add(1,1,1,1, 0,8'h00,0,0);
    add(1,1,1,1, 1,8'h00,0,0);
    add(1,1,1,1, 0,8'h00,1,0);
    add(1,1,1,1, 0,8'h00,0,0);
    add(1,1,1,1, 1,8'h01,0,0);
    add(1,1,1,1, 0,8'h00,0,1);
    add(1,1,1,1, 0,8'h00,0,0);
    add(1,1,1,1, 1,8'h00,0,0);
    add(1,1,1,1, 0,8'h00,1,0);
    add(0,0,1,0, 0,8'h00,0,0);
    add(0,1,1,0, 1,8'h01,0,0);
    add(0,0,0,0, 1,8'h01,0,0);
    add(1,0,0,0, 1,8'h01,0,0);
    add(1,0,0,1, 0,8'h00,0,1);
    add(0,0,1,0, 0,8'h00,0,0);
    add(1,0,0,0, 0,8'h00,0,0);
    add(1,0,0,0, 0,8'h00,0,0);
    add(0,0,1,0, 0,8'h00,0,0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, cfg_interrupt, cfg_interrupt_di == 8'h00 ? 1'b0 : 1'b1, rx_irq_ack, tx_irq_ack, 1'b0}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rx_irq_req        = tbl[i].rx;
      tx_irq_req        = tbl[i].tx;
      irq_enable        = tbl[i].en;
      cfg_interrupt_rdy = tbl[i].rdy;
      step();
      act = {1'b0, cfg_interrupt, tbl[i].e_int ? cfg_interrupt_di : 8'h00, rx_irq_ack, tx_irq_ack};
      exp = {1'b0, tbl[i].e_int, tbl[i].e_int ? tbl[i].e_di : 8'h00, tbl[i].e_rack, tbl[i].e_tack};
      if (act !== exp) $display("row %0d differs", i);
      chk($sformatf("vec%0d", i), {20'd0, act}, {20'd0, exp});
    end

    // Holdoff spacing; the mid-holdoff change must only affect the next load.
    holdoff_cycles    = 16'd10;
    rx_irq_req        = 1'b1;
    tx_irq_req        = 1'b1;
    irq_enable        = 1'b1;
    cfg_interrupt_rdy = 1'b1;
    wait_rise("rise1", t1);
    chk("rise1_di", {24'd0, cfg_interrupt_di}, 32'h00);
    repeat (3) step();
    holdoff_cycles = 16'd2;
    wait_rise("rise2", t2);
    chk("rise2_di", {24'd0, cfg_interrupt_di}, 32'h01);
    chk("gap_holdoff10", t2 - t1, 32'd13);
    wait_rise("rise3", t3);
    chk("rise3_di", {24'd0, cfg_interrupt_di}, 32'h00);
    chk("gap_holdoff2", t3 - t2, 32'd5);
    holdoff_cycles = 16'd0;
    rx_irq_req     = 1'b0;
    tx_irq_req     = 1'b0;
    repeat (4) step();
    cfg_interrupt_rdy = 1'b0;

    // Disabled with a pending Tx level, then enabled.
    irq_enable = 1'b0;
    tx_irq_req = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cfg_interrupt) highs = highs + 1;
    end
    chk("disabled_no_irq", highs, 32'd0);
    irq_enable = 1'b1;
    step();
    chk("enable_irq", {23'd0, cfg_interrupt, cfg_interrupt_di}, {23'd0, 1'b1, 8'h01});
    cfg_interrupt_rdy = 1'b1;
    step();
    chk("enable_ack", {29'd0, cfg_interrupt, rx_irq_ack, tx_irq_ack}, 32'b001);
    cfg_interrupt_rdy = 1'b0;
    tx_irq_req        = 1'b0;
    step();
    chk("ack_single", {30'd0, rx_irq_ack, tx_irq_ack}, 32'd0);
    repeat (2) step();

    // Leave last-grant at Rx, then reset during a Tx request.
    rx_irq_req = 1'b1;
    step();
    cfg_interrupt_rdy = 1'b1;
    step();
    chk("pre_rst_rx_ack", {31'd0, rx_irq_ack}, 32'd1);
    cfg_interrupt_rdy = 1'b0;
    rx_irq_req        = 1'b0;
    repeat (2) step();
    tx_irq_req = 1'b1;
    step();
    chk("pre_rst_tx_irq", {23'd0, cfg_interrupt, cfg_interrupt_di}, {23'd0, 1'b1, 8'h01});
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_drop", {29'd0, cfg_interrupt, rx_irq_ack, tx_irq_ack}, 32'd0);
    cfg_interrupt_rdy = 1'b1;
    step();
    step();
    chk("rst_no_ack", {29'd0, cfg_interrupt, rx_irq_ack, tx_irq_ack}, 32'd0);
    reset             = 1'b0;
    cfg_interrupt_rdy = 1'b0;
    rx_irq_req        = 1'b1;
    tx_irq_req        = 1'b1;
    step();
    chk("post_rst_tie_rx", {23'd0, cfg_interrupt, cfg_interrupt_di}, {23'd0, 1'b1, 8'h00});
    cfg_interrupt_rdy = 1'b1;
    step();
    chk("post_rst_rx_ack", {29'd0, cfg_interrupt, rx_irq_ack, tx_irq_ack}, 32'b010);
    rx_irq_req        = 1'b0;
    tx_irq_req        = 1'b0;
    cfg_interrupt_rdy = 1'b0;
    repeat (3) step();

    chk("ack_exclusive", both_acks, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
